dram_port_arbiter: RTL
======================

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, 20, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, 32, memory data width.
REQ-003 The block SHALL have parameter STARVE_MAX, 4, consecutive CPU grants tolerated while EXT waits (guard build only).
REQ-004 The block SHALL have ports: clk  in  1  single clock, all state on rising edge; rst  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have CPU-side ports: cpu_req  in  1  access request; cpu_we  in  1  write when 1; cpu_addr  in  ADDR_W  address; cpu_wdata  in  DATA_W  write data; cpu_ack  out  1  one-cycle completion pulse; cpu_rdata  out  DATA_W  read data.
REQ-006 The block SHALL have EXT-side (Arduino bridge) ports: ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rdata, with the same directions and widths as the CPU side.
REQ-007 The block SHALL have memory-side ports: mem_addr  out  ADDR_W  address; mem_wdata  out  DATA_W  write data; mem_wen  out  1  write strobe; mem_rdata  in  DATA_W  read data, valid one cycle after mem_addr.
REQ-008 The block SHALL have port: busy  out  1  high when state is not IDLE.

Function
REQ-009 The FSM SHALL have states IDLE, ACCESS, and RESP, encoded in 2 bits.
REQ-010 In IDLE, if either request is high, the FSM SHALL latch the winner (owner bit) and the winner's we/addr/wdata, and then move to ACCESS.
REQ-011 In IDLE with no request, the FSM SHALL remain in IDLE with mem_wen=0.
REQ-012 In ACCESS, the block SHALL drive mem_addr/mem_wdata from the latched values, assert mem_wen for exactly one cycle if the latched we=1, and then move to RESP.
REQ-013 In RESP, the block SHALL pulse the owner's ack for exactly one cycle, drive the owner's rdata from mem_rdata (held until that owner's next ack; write accesses leave rdata unchanged), and then move to IDLE.
REQ-014 Each access SHALL take 3 cycles from request sample to ack; back-to-back accesses are sampled in the IDLE cycle following RESP.
REQ-015 A requester SHALL hold req/we/addr/wdata stable until its ack; the block samples them only in IDLE.
REQ-016 When cpu_req and ext_req are both high in IDLE, CPU SHALL win (without the guard) or as modified by REQ-023.
REQ-017 The non-owner's ack SHALL stay 0 throughout an access; a request arriving mid-access SHALL wait for IDLE.
REQ-018 mem_wen SHALL never be asserted outside ACCESS.
REQ-019 mem_addr and mem_wdata SHALL hold their last values outside ACCESS (no glitching to 0).

Reset
REQ-020 When rst=0, the block SHALL asynchronously force state=IDLE, the owner to CPU, all latched fields to 0, cpu_ack=ext_ack=0, mem_wen=0, cpu_rdata=ext_rdata=0, mem_addr=mem_wdata=0, busy=0, and the starve counter to 0.
REQ-021 Reset asserted during ACCESS or RESP SHALL abort the access: no ack issued, and no write issued after the cycle in which reset is asserted.
REQ-022 After rst deasserts, the first request SHALL be sampled on the first rising edge in IDLE.

Configuration
REQ-023 With ARB_STARVE_GUARD_EN defined, a saturating counter SHALL increment on each CPU grant made while ext_req=1, clear on any EXT grant, and force an EXT grant when both request and the counter equals STARVE_MAX.
REQ-024 Without ARB_STARVE_GUARD_EN, the counter SHALL not exist and CPU SHALL have fixed priority.

Verification
REQ-025 A CPU write of addr 0x00010 with data 0xDEADBEEF, followed by a CPU read of 0x00010, SHALL produce mem_wen high for exactly one cycle, then cpu_ack 3 cycles after req with cpu_rdata=0xDEADBEEF.
REQ-026 An EXT read of addr 0x00003 with the memory holding 0x0000000A SHALL produce ext_ack 3 cycles later with ext_rdata=0xA and cpu_ack=0 throughout.
REQ-027 Both req held high continuously without the guard SHALL produce only cpu_ack pulses every 3 cycles and ext_ack never.
REQ-028 Both req held high continuously with ARB_STARVE_GUARD_EN and STARVE_MAX=4 SHALL produce 4 cpu_acks, then 1 ext_ack, repeating.
REQ-029 rst pulled low in the ACCESS cycle of a CPU write SHALL produce no cpu_ack, mem_wen=0 immediately, and busy=0.
REQ-030 An ext_req rising during a CPU access SHALL be granted in the IDLE cycle after cpu_ack, with ext_ack 3 cycles after that.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Two-port (CPU, EXT) arbiter onto one synchronous memory: IDLE/ACCESS/RESP, ack in RESP (3 cycles), requesters hold until ack.
// Define ARB_STARVE_GUARD_EN to force an EXT grant after STARVE_MAX consecutive CPU wins while EXT waits.
module dram_port_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  if (STARVE_MAX < 1) begin : gBadStarveMax
    $error("dram_port_arbiter: STARVE_MAX must be at least 1");
  end

  state_t            stateQ;
  state_t            stateD;
  logic              ownerExtQ;
  logic              latWeQ;
  logic [ADDR_W-1:0] latAddrQ;
  logic [DATA_W-1:0] latWdataQ;
  logic [DATA_W-1:0] cpuRdataQ;
  logic [DATA_W-1:0] extRdataQ;
  logic              grantCpu;
  logic              grantExt;
  logic              forceExt;
  logic              respRead;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starveCntQ;

  // Saturates at CNT_MAX so EXT keeps winning contested slots until it is served.
  assign forceExt = ext_req && (starveCntQ == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCntQ <= '0;
    end else if (grantExt) begin
      starveCntQ <= '0;
    end else if (grantCpu && ext_req && (starveCntQ != CNT_MAX)) begin
      starveCntQ <= starveCntQ + 1'b1;
    end
  end
`else
  assign forceExt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    grantCpu = 1'b0;
    grantExt = 1'b0;
    mem_wen  = 1'b0;
    cpu_ack  = 1'b0;
    ext_ack  = 1'b0;
    busy     = 1'b1;
    unique case (stateQ)
      IDLE: begin
        busy = 1'b0;
        if (cpu_req || ext_req) begin
          grantExt = ext_req && (!cpu_req || forceExt);
          grantCpu = cpu_req && !forceExt;
          stateD   = ACCESS;
        end
      end
      ACCESS: begin
        mem_wen = latWeQ;
        stateD  = RESP;
      end
      RESP: begin
        cpu_ack = !ownerExtQ;
        ext_ack = ownerExtQ;
        stateD  = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // The latched address/data double as the memory bus, so it holds between accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ownerExtQ <= 1'b0;
      latWeQ    <= 1'b0;
      latAddrQ  <= '0;
      latWdataQ <= '0;
    end else if (grantCpu) begin
      ownerExtQ <= 1'b0;
      latWeQ    <= cpu_we;
      latAddrQ  <= cpu_addr;
      latWdataQ <= cpu_wdata;
    end else if (grantExt) begin
      ownerExtQ <= 1'b1;
      latWeQ    <= ext_we;
      latAddrQ  <= ext_addr;
      latWdataQ <= ext_wdata;
    end
  end

  assign mem_addr  = latAddrQ;
  assign mem_wdata = latWdataQ;

  // Read data is live in RESP alongside ack, then captured so it stays put afterwards.
  assign respRead = (stateQ == RESP) && !latWeQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpuRdataQ <= '0;
      extRdataQ <= '0;
    end else if (respRead) begin
      if (ownerExtQ) begin
        extRdataQ <= mem_rdata;
      end else begin
        cpuRdataQ <= mem_rdata;
      end
    end
  end

  assign cpu_rdata = (respRead && !ownerExtQ) ? mem_rdata : cpuRdataQ;
  assign ext_rdata = (respRead && ownerExtQ)  ? mem_rdata : extRdataQ;

endmodule
